// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 prefix constants, frame states and event type
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_event_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_scan_fifo_if.sv
// rtl/ps2_scan_fifo_if.sv - decoded scan-code event port between front end and translator
interface ps2_scan_fifo_if #(parameter int DEPTH = 8);
    logic                   rd_en;
    logic                   code_valid;
    logic [7:0]             code_out;
    logic                   code_break;
    logic                   code_ext;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   overflow;

    modport master (input rd_en, output code_valid, code_out, code_break, code_ext, fifo_count, overflow);
    modport slave  (output rd_en, input code_valid, code_out, code_break, code_ext, fifo_count, overflow);
endinterface

// File: rtl/ps2_event_fifo.sv
// rtl/ps2_event_fifo.sv - DEPTH-entry show-ahead event FIFO with count/full/empty
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  ps2_event_t             wr_data,
    input  logic                   rd_en,
    output ps2_event_t             rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    ps2_event_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = rd_en && !empty;
    // a full FIFO still accepts a write when the head leaves in the same cycle
    assign do_push = wr_en && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/ps2_scan_fifo.sv
// rtl/ps2_scan_fifo.sv - PS/2 frame receiver, prefix merge and event FIFO; PS2_PARITY_CHECK_EN adds odd-parity check
module ps2_scan_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 20000
) (
    input  logic sys_clk,
    input  logic rst,
    input  logic ps2_clk,
    input  logic ps2_data,
    ps2_scan_fifo_if.master evt
`ifdef PS2_PARITY_CHECK_EN
    ,output logic parity_err
`endif
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]  clk_sync;
    logic [1:0]  data_sync;
    logic        clk_prev;
    logic        fall;
    logic        data_s;
    ps2_state_e  state_q;
    ps2_state_e  state_d;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_q;
    logic [TW-1:0] idle_cnt;
    logic        timeout;
    logic        frame_done;
    logic        frame_ok;
    logic        parity_ok;
    logic        accept_stb;
    logic        push_req;
    logic        ext_pend;
    logic        brk_pend;
    logic        overflow_q;
    ps2_event_t  head;
    logic        full;
    logic        empty;

    assign fall    = !clk_sync[1] && clk_prev;
    assign data_s  = data_sync[1];
    assign timeout = (state_q != IDLE) && (idle_cnt == TW'(TIMEOUT));

`ifdef PS2_PARITY_CHECK_EN
    logic par_bit;
    assign parity_ok = ^{shift_q, par_bit};
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        frame_done = 1'b0;
        if (timeout) begin
            state_d = IDLE;
        end else if (fall) begin
            unique case (state_q)
                IDLE:    if (!data_s) state_d = DATA;
                DATA:    if (bit_idx == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    begin state_d = IDLE; frame_done = 1'b1; end
                default: state_d = IDLE;
            endcase
        end
        frame_ok = frame_done && data_s && parity_ok;
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_prev   <= 1'b1;
            state_q    <= IDLE;
            bit_idx    <= '0;
            shift_q    <= '0;
            idle_cnt   <= '0;
            accept_stb <= 1'b0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            clk_prev   <= clk_sync[1];
            state_q    <= state_d;
            accept_stb <= frame_ok;
            idle_cnt   <= (fall || state_q == IDLE) ? '0 : idle_cnt + TW'(1);
            if (fall && !timeout) begin
                if (state_q == IDLE) bit_idx <= '0;
                if (state_q == DATA) begin
                    shift_q <= {data_s, shift_q[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end
        end
    end

`ifdef PS2_PARITY_CHECK_EN
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (fall && !timeout && state_q == PARITY) par_bit <= data_s;
            if (frame_done && data_s && !parity_ok) parity_err <= 1'b1;
        end
    end
`endif

    // shift_q stays stable until the next frame's data bits, so it is the accepted byte here
    assign push_req = accept_stb && !is_prefix(shift_q);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            ext_pend   <= 1'b0;
            brk_pend   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (accept_stb) begin
                if (shift_q == PS2_EXT)      ext_pend <= 1'b1;
                else if (shift_q == PS2_BRK) brk_pend <= 1'b1;
                else begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            end
            if (push_req && full && !(evt.rd_en && !empty)) overflow_q <= 1'b1;
        end
    end

    ps2_event_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (sys_clk),
        .rst     (rst),
        .wr_en   (push_req),
        .wr_data ('{ext: ext_pend, brk: brk_pend, code: shift_q}),
        .rd_en   (evt.rd_en),
        .rd_data (head),
        .count   (evt.fifo_count),
        .full    (full),
        .empty   (empty)
    );

    assign evt.code_valid = !empty;
    assign evt.code_out   = head.code;
    assign evt.code_break = head.brk;
    assign evt.code_ext   = head.ext;
    assign evt.overflow   = overflow_q;
endmodule

// File: tb/tb_ps2_scan_fifo.sv
// tb/tb_ps2_scan_fifo.sv - directed bench for ps2_scan_fifo
module tb_ps2_scan_fifo;
    localparam int DEPTH = 8;
    localparam int HALF  = 20;

    logic sys_clk  = 1'b0;
    logic rst      = 1'b1;
    logic ps2_clk  = 1'b1;
    logic ps2_data = 1'b1;
    int   total    = 0;
    int   bad      = 0;
    int   found;
    int   lat;

    ps2_scan_fifo_if #(.DEPTH(DEPTH)) evt ();
`ifdef PS2_PARITY_CHECK_EN
    logic parity_err;
`endif

    ps2_scan_fifo #(.DEPTH(DEPTH), .TIMEOUT(200)) dut (
        .sys_clk  (sys_clk),
        .rst      (rst),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .evt      (evt)
`ifdef PS2_PARITY_CHECK_EN
        ,.parity_err (parity_err)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic ps2_bit(input logic d);
        ps2_data = d;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b1;
    endtask

    // start, data and parity bits; the caller drives the stop bit
    task automatic send_head(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad_par);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        send_head(b, bad_par);
        ps2_bit(1'b1);
        wait_cyc(4);
    endtask

    task automatic pop_check(input string tag, input logic [9:0] exp);
        check(tag, 32'({evt.code_valid, evt.code_ext, evt.code_break, evt.code_out}), 32'({1'b1, exp}));
        evt.rd_en = 1'b1;
        wait_cyc(1);
        evt.rd_en = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        evt.rd_en = 1'b0;
        wait_cyc(3);
        check("reset_outs", 32'({evt.code_valid, evt.code_out, evt.code_break, evt.code_ext,
                                 evt.fifo_count, evt.overflow}), 0);
        rst = 1'b0;
        wait_cyc(5);

        // single make code with stop-edge latency bound
        send_head(8'h1C, 1'b0);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        found = 0;
        lat = 0;
        for (int k = 1; k <= 5; k++) begin
            wait_cyc(1);
            if (evt.code_valid && found == 0) begin
                found = 1;
                lat = k;
            end
        end
        check("latency_seen", 32'(found), 1);
        check("latency_le5", 32'(lat >= 1 && lat <= 5), 1);
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(4);
        check("count_one", 32'(evt.fifo_count), 1);
        pop_check("pop_1c", 10'h01C);
        check("empty_after_pop", 32'({evt.code_valid, evt.fifo_count}), 0);
        evt.rd_en = 1'b1;
        wait_cyc(2);
        evt.rd_en = 1'b0;
        check("rd_empty_ignored", 32'({evt.code_valid, evt.fifo_count}), 0);

        // prefixes merge into flags and never push on their own
        send_byte(8'hF0, 1'b0);
        check("prefix_no_push", 32'(evt.fifo_count), 0);
        send_byte(8'h1C, 1'b0);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("prefix_count", 32'(evt.fifo_count), 2);
        pop_check("pop_brk_1c", 10'h11C);
        pop_check("pop_ext_brk_75", 10'h375);

        // overflow: nine codes into eight entries
        for (int i = 0; i < DEPTH + 1; i++) send_byte(8'h10 + 8'(i), 1'b0);
        check("full_count", 32'(evt.fifo_count), DEPTH);
        check("overflow_set", 32'(evt.overflow), 1);
        for (int i = 0; i < DEPTH; i++) pop_check("pop_ovf", 10'h010 + 10'(i));
        check("ovf_drained", 32'(evt.code_valid), 0);
        check("overflow_sticky", 32'(evt.overflow), 1);

        // push into a full FIFO with a pop in the same cycle
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_byte(8'h30 + 8'(i), 1'b0);
        check("refill_count", 32'(evt.fifo_count), DEPTH);
        send_head(8'h22, 1'b0);
        ps2_data = 1'b1;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(3);
        evt.rd_en = 1'b1;
        wait_cyc(1);
        evt.rd_en = 1'b0;
        check("simul_count", 32'(evt.fifo_count), DEPTH);
        check("simul_no_ovf", 32'(evt.overflow), 0);
        wait_cyc(HALF);
        ps2_clk = 1'b1;
        wait_cyc(4);
        for (int i = 1; i < DEPTH; i++) pop_check("pop_simul", 10'h030 + 10'(i));
        pop_check("pop_tail_22", 10'h022);

        // stalled frame is abandoned by the timeout
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        wait_cyc(250);
        send_byte(8'h2A, 1'b0);
        check("timeout_count", 32'(evt.fifo_count), 1);
        pop_check("timeout_2a", 10'h02A);

        // reset mid-frame clears FIFO, flags and the partial frame
        send_byte(8'h33, 1'b0);
        send_byte(8'hF0, 1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_data = 1'b0;
        wait_cyc(HALF);
        ps2_clk = 1'b0;
        wait_cyc(3);
        rst = 1'b1;
        wait_cyc(1);
        check("rst_mid_outs", 32'({evt.code_valid, evt.code_out, evt.code_break, evt.code_ext,
                                   evt.fifo_count, evt.overflow}), 0);
        rst = 1'b0;
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(10);
        send_byte(8'h2A, 1'b0);
        check("rst_mid_count", 32'(evt.fifo_count), 1);
        pop_check("rst_mid_2a", 10'h02A);

`ifdef PS2_PARITY_CHECK_EN
        send_byte(8'hF0, 1'b0);
        send_byte(8'h1C, 1'b1);
        check("par_bad_no_push", 32'(evt.fifo_count), 0);
        check("par_err_set", 32'(parity_err), 1);
        send_byte(8'h1C, 1'b0);
        check("par_good_count", 32'(evt.fifo_count), 1);
        pop_check("par_good_1c", 10'h11C);
        check("par_err_sticky", 32'(parity_err), 1);
        ps2_bit(1'b0);
        rst = 1'b1;
        wait_cyc(1);
        check("par_rst_outs", 32'({parity_err, evt.code_valid, evt.code_out, evt.code_break,
                                   evt.code_ext, evt.fifo_count, evt.overflow}), 0);
        rst = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ps2_scan_fifo.md
Name: ps2_scan_fifo

Overview:
- PS/2 keyboard front end: deserializes device frames from raw ps2_clk/ps2_data pins into decoded scan-code events.
- Merges E0 (extended) and F0 (break) prefixes into per-event flags.
- Buffers events in a show-ahead FIFO.
- Sits directly upstream of the scan-code-to-ASCII translator that drives the keyboard word in CPU memory; that translator pops one event at a time.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- TIMEOUT, 20000, sys_clk cycles without a ps2_clk falling edge before an in-progress frame is abandoned.

Ports:
- sys_clk  input  1  system clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock pin, asynchronous.
- ps2_data  input  1  raw PS/2 data pin, asynchronous.
- rd_en  input  1  pop request from the consumer.
- code_valid  output  1  FIFO non-empty; head event presented.
- code_out  output  8  head scan code (prefixes stripped).
- code_break  output  1  head event is a key release (F0 seen).
- code_ext  output  1  head event is extended (E0 seen).
- fifo_count  output  $clog2(DEPTH)+1  occupancy.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.

Behaviour:
- Reset (sync, active-high, sampled on posedge sys_clk):
  - All outputs 0.
  - FIFO empty; prefix flags cleared; FSM to IDLE; synchronizers loaded with 1.
  - Reset mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - A falling edge is the cycle where synced ps2_clk is 0 and its previous value was 1.
  - All bit sampling uses synced ps2_data on that cycle.
- Frame FSM (advances only on falling edges, except timeout):
  - IDLE: data=0 -> DATA with bit index 0; data=1 -> stay (glitch reject).
  - DATA: shift in LSB first; after the 8th bit -> PARITY.
  - PARITY: capture bit -> STOP.
  - STOP: data=1 (and parity ok, see Optional Feature) -> byte accepted. Any other value -> frame discarded. Either way -> IDLE.
  - Timeout: an idle counter clears on each falling edge. If it reaches TIMEOUT while not in IDLE -> IDLE, partial frame discarded. It never fires in IDLE.
- Byte handling (one cycle after the accept edge):
  - 0xE0: set ext_pend; no push.
  - 0xF0: set brk_pend; no push.
  - Any other byte: push {ext_pend, brk_pend, byte}, then clear both pending flags.
  - Pending flags persist across any number of prefixes; repeated prefixes are idempotent.
- FIFO:
  - 10-bit entries, circular, DEPTH entries.
  - Pointer wrap is modulo DEPTH; fifo_count ranges 0..DEPTH.
  - Show-ahead: code_out/code_break/code_ext reflect the head whenever code_valid=1. They hold their last value when empty and are don't-care.
  - Pop: rd_en && code_valid advances the head. The next head, or code_valid=0, is visible the following cycle.
  - rd_en while empty is ignored.
  - Push to empty: code_valid=1 exactly 1 cycle after the push cycle.
  - Push while full without a simultaneous pop: event dropped, overflow set.
  - Push while full with a simultaneous pop: both succeed; count stays DEPTH.
  - Simultaneous push and pop at any other count: count unchanged.
  - overflow clears only on rst.
- Latency: falling edge of the stop bit on the pin to code_valid is at most 5 sys_clk cycles (2 sync + edge + decode + FIFO write).

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined:
  - Odd parity is checked over data+parity; a mismatch at STOP discards the byte.
  - A pending prefix is not consumed by a discarded byte.
  - Extra output parity_err (1 bit), sticky, cleared by rst.
- Undefined:
  - Parity bit captured but ignored.
  - parity_err port absent.
  - Any frame with valid start/stop bits is accepted.

Decomposition:
- Shared package ps2_pkg:
  - Prefix constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - FSM state enum {IDLE, DATA, PARITY, STOP}.
  - Packed event type {ext, brk, code[7:0]}.
- One sub-module, ps2_event_fifo: a generic DEPTH x 10 show-ahead FIFO exposing count/full/empty. The frame FSM and prefix logic stay in the top.

Test Plan (bench drives ps2_clk at ~10 kHz equivalent, scaled; TIMEOUT overridden to 200 for sim):
- Send frame 0x1C, consumer idle -> within 5 cycles of the stop edge: code_valid=1, code_out=0x1C, break=0, ext=0, fifo_count=1.
- Send F0,1C then E0,F0,75 -> two events: {0,1,0x1C} then {1,1,0x75}; no events are pushed for the prefix bytes.
- Send DEPTH+1 codes 0x10..0x18 with no pops -> fifo_count=8, overflow=1. Pops return 0x10..0x17 in order; 0x18 is lost.
- With FIFO full, assert rd_en in the same cycle a new byte 0x22 is accepted -> count stays 8, overflow stays 0, 0x22 lands at the tail.
- Stop ps2_clk after 4 data bits for 250 cycles, then send a full 0x2A frame -> only 0x2A is pushed; no corrupt event.
- With PS2_PARITY_CHECK_EN defined, send 0x1C with inverted parity -> no push, parity_err=1. The next good 0x1C is pushed normally. Assert rst mid-frame -> all outputs 0 the next cycle.
